if_fetch_queue: RTL and testbench
=================================

Name: if_fetch_queue

Overview:
Parametrised successor to the single-register fetch stage. It drives a request/grant/response instruction-memory interface and tolerates variable memory latency. Fetched instructions are buffered in a QDEPTH-entry FIFO of {PC, IR} pairs. Supports downstream stall (hazard), taken-branch redirect, and discard of in-flight wrong-path responses. Sits between instruction memory and the IF/ID pipeline register.

Parameters:
XLEN, 32, PC/instruction width
QDEPTH, 4, FIFO entries (power of 2, >=2); also caps requests in flight
RESET_PC, 0, PC loaded on reset

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
ex_take_branch_out  in  1  redirect fetch this cycle
ex_target_PC_out  in  XLEN  redirect target
hazard  in  1  downstream stall; head not consumed
proc2Imem_req  out  1  fetch request valid
proc2Imem_addr  out  XLEN  word-aligned fetch address
Imem2proc_gnt  in  1  memory accepts request this cycle
Imem2proc_valid  in  1  response valid; in order; at least 1 cycle after its grant
Imem2proc_data  in  XLEN  response instruction
if_valid_out  out  1  head entry valid
if_PC_out  out  XLEN  head PC
if_NPC_out  out  XLEN  head PC + 4
if_IR_out  out  XLEN  head instruction

Behaviour:
- Reset is async, active-high, and may assert mid-operation. It sets fetch_pc=RESET_PC and clears FIFO count, pointers, outstanding and drop_cnt. Responses arriving after reset are ignored only if counted (none are), so memory must also be reset.
- Reset output values: proc2Imem_req=0 for the reset cycle; if_valid_out=0; if_PC/NPC/IR_out=0.
- proc2Imem_addr = {fetch_pc[XLEN-1:2],2'b00} at all times.
- Issue condition: proc2Imem_req = !ex_take_branch_out && (count + outstanding - drop_cnt) < QDEPTH. This credit rule guarantees a FIFO slot for every accepted response.
- Accept: req && gnt. fetch_pc += 4 and the accepted request is recorded as outstanding with its PC, held in a QDEPTH-deep PC tag FIFO. The address must stay stable while req is high and gnt is low.
- Response: on Imem2proc_valid, outstanding decrements.
  - If drop_cnt>0, drop_cnt decrements and the data is discarded.
  - Otherwise {tag PC, data} is written to the FIFO tail.
- Output: if_valid_out = (count!=0) && !ex_take_branch_out. The head is combinational from the FIFO, and if_NPC_out = head PC + 4. Outputs read 0 when empty.
- Dequeue when if_valid_out && !hazard. Simultaneous enqueue and dequeue with a full FIFO is legal, because the credit rule already reserved the slot.
- Redirect (ex_take_branch_out=1):
  - The FIFO is flushed with count=0, and no dequeue occurs that cycle.
  - fetch_pc <= {ex_target_PC_out[XLEN-1:2],2'b00}.
  - drop_cnt <= outstanding minus a response arriving that cycle; that response is itself discarded. No request is issued that cycle.
- Redirect while drop_cnt>0 follows the same rule; the total of all in-flight responses becomes drop_cnt.
- Wrap-around: FIFO pointers are log2(QDEPTH) bits and wrap naturally. fetch_pc wraps modulo 2^XLEN.
- Assertion checks:
  - Imem2proc_valid with outstanding==0 is a protocol error.
  - count never exceeds QDEPTH.

Optional Feature:
IF_FETCH_STATS_EN.
- Defined: adds outputs stat_fetched (32 bits, responses enqueued), stat_dropped (32 bits, responses discarded) and stat_stall (32 bits, cycles with if_valid_out && hazard). All three clear on reset and saturate at all-ones.
- Undefined: those ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package if_pkg holds:
  - typedef fetch_entry_t {pc, ir}
  - localparam PTR_W = $clog2(QDEPTH)
  - the instruction NOP constant, used by the bench for fill
- One natural sub-module, if_sync_fifo, is instantiated twice: the entry FIFO and the PC tag FIFO. It is parametrised by width and depth, with flush, push, pop, count and a full/empty pair.

Test Plan:
1. Reset, then gnt=1 and 1-cycle memory, hazard=0. Required: addresses 0x0,0x4,0x8,... issued back-to-back; if_valid_out=1 from cycle 3; if_PC_out advances by 4 each cycle and if_NPC_out = PC+4.
2. hazard held high, QDEPTH=4. Required: exactly 4 grants, then req=0 and count=4. Release hazard and the head sequence continues 0x0,0x4 with no gaps or duplicates.
3. Memory latency 3 cycles with 2 outstanding. Branch to 0x103 arrives. Required: both late responses dropped; next addr=0x100; first output PC=0x100; stat_dropped=2 if enabled.
4. Branch in the same cycle as a response and a full FIFO. Required: response discarded, if_valid_out=0 that cycle, FIFO empty the next cycle.
5. Async rst pulse mid-stream with 2 outstanding. Required: outputs 0 immediately; after release the first addr is RESET_PC.
6. gnt held low for 5 cycles. Required: proc2Imem_addr stable and req held; no PC advance.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch queue and its FIFOs.
package if_pkg;

   localparam int unsigned IF_XLEN   = 32;
   localparam int unsigned IF_QDEPTH = 4;
   localparam int unsigned PTR_W     = $clog2(IF_QDEPTH);

   // addi x0,x0,0: filler instruction for idle data buses
   localparam logic [IF_XLEN-1:0] NOP = 32'h0000_0013;

   typedef struct packed {
      logic [IF_XLEN-1:0] pc;
      logic [IF_XLEN-1:0] ir;
   } fetch_entry_t;

endpackage

// File: rtl/if_sync_fifo.sv
// Synchronous FIFO with flush; push while full is accepted when a pop happens the same cycle.
module if_sync_fifo #(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     flush,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         cnt_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = wdata;
            wr_ptr_d        = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
         end
         cnt_d = cnt_q + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = cnt_q;
   assign full  = (cnt_q == CW'(DEPTH));
   assign empty = (cnt_q == '0);

endmodule

// File: rtl/if_fetch_queue.sv
// Queued instruction fetch stage over a req/gnt/valid memory port, with redirect and wrong-path drop.
// Optional statistics counters are enabled with IF_FETCH_STATS_EN.
module if_fetch_queue import if_pkg::*; #(
   parameter int unsigned      XLEN     = IF_XLEN,
   parameter int unsigned      QDEPTH   = IF_QDEPTH,
   parameter logic [XLEN-1:0]  RESET_PC = '0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ex_take_branch_out,
   input  logic [XLEN-1:0]  ex_target_PC_out,
   input  logic             hazard,
   output logic             proc2Imem_req,
   output logic [XLEN-1:0]  proc2Imem_addr,
   input  logic             Imem2proc_gnt,
   input  logic             Imem2proc_valid,
   input  logic [XLEN-1:0]  Imem2proc_data,
   output logic             if_valid_out,
   output logic [XLEN-1:0]  if_PC_out,
   output logic [XLEN-1:0]  if_NPC_out,
   output logic [XLEN-1:0]  if_IR_out
`ifdef IF_FETCH_STATS_EN
   ,
   output logic [31:0]      stat_fetched,
   output logic [31:0]      stat_dropped,
   output logic [31:0]      stat_stall
`endif
);

   localparam int unsigned QPTR_W = $clog2(QDEPTH);
   localparam int unsigned CW     = QPTR_W + 1;
   localparam int unsigned SW     = QPTR_W + 3;
   localparam int unsigned EW     = 2 * XLEN;

   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [CW-1:0]   outstanding_q, outstanding_d;
   logic [CW-1:0]   drop_cnt_q, drop_cnt_d;

   logic            e_push, e_pop, e_full, e_empty;
   logic [EW-1:0]   e_wdata, e_rdata;
   logic [CW-1:0]   e_count;
   logic            t_push, t_pop, t_full, t_empty;
   logic [XLEN-1:0] t_rdata;
   logic [CW-1:0]   t_count;

   logic [SW-1:0]   credit_sum;
   logic            accept, resp_drop, resp_keep;

   if_sync_fifo #(.WIDTH(EW), .DEPTH(QDEPTH)) u_entry_fifo (
      .clk(clk), .rst(rst), .flush(ex_take_branch_out),
      .push(e_push), .pop(e_pop), .wdata(e_wdata), .rdata(e_rdata),
      .count(e_count), .full(e_full), .empty(e_empty)
   );

   // PCs of live (non-discarded) requests, in issue order
   if_sync_fifo #(.WIDTH(XLEN), .DEPTH(QDEPTH)) u_tag_fifo (
      .clk(clk), .rst(rst), .flush(ex_take_branch_out),
      .push(t_push), .pop(t_pop), .wdata(fetch_pc_q), .rdata(t_rdata),
      .count(t_count), .full(t_full), .empty(t_empty)
   );

   always_comb begin
      // queued + live in-flight entries must leave a slot for every response
      credit_sum    = SW'(e_count) + SW'(outstanding_q) - SW'(drop_cnt_q);
      proc2Imem_req = !rst && !ex_take_branch_out && (credit_sum < SW'(QDEPTH));
      accept        = proc2Imem_req && Imem2proc_gnt;
      resp_drop     = Imem2proc_valid && ((drop_cnt_q != '0) || ex_take_branch_out);
      resp_keep     = Imem2proc_valid && !resp_drop;
      if_valid_out  = !e_empty && !ex_take_branch_out;

      e_push  = resp_keep;
      e_pop   = if_valid_out && !hazard;
      e_wdata = {t_rdata, Imem2proc_data};
      t_push  = accept;
      t_pop   = resp_keep;

      fetch_pc_d    = fetch_pc_q;
      outstanding_d = outstanding_q + CW'(accept) - CW'(Imem2proc_valid);
      drop_cnt_d    = drop_cnt_q;
      if (ex_take_branch_out) begin
         fetch_pc_d = ex_target_PC_out & ~XLEN'(3);
         drop_cnt_d = outstanding_q - CW'(Imem2proc_valid);
      end else begin
         if (accept) begin
            fetch_pc_d = fetch_pc_q + XLEN'(4);
         end
         if (resp_drop) begin
            drop_cnt_d = drop_cnt_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc_q    <= RESET_PC;
         outstanding_q <= '0;
         drop_cnt_q    <= '0;
      end else begin
         fetch_pc_q    <= fetch_pc_d;
         outstanding_q <= outstanding_d;
         drop_cnt_q    <= drop_cnt_d;
      end
   end

   assign proc2Imem_addr = fetch_pc_q & ~XLEN'(3);
   assign if_PC_out      = e_empty ? '0 : e_rdata[EW-1:XLEN];
   assign if_IR_out      = e_empty ? '0 : e_rdata[XLEN-1:0];
   assign if_NPC_out     = e_empty ? '0 : e_rdata[EW-1:XLEN] + XLEN'(4);

`ifdef IF_FETCH_STATS_EN
   logic [31:0] stat_fetched_q, stat_fetched_d;
   logic [31:0] stat_dropped_q, stat_dropped_d;
   logic [31:0] stat_stall_q, stat_stall_d;

   // saturating event counters
   always_comb begin
      stat_fetched_d = stat_fetched_q;
      stat_dropped_d = stat_dropped_q;
      stat_stall_d   = stat_stall_q;
      if (resp_keep && (stat_fetched_q != '1)) stat_fetched_d = stat_fetched_q + 32'd1;
      if (resp_drop && (stat_dropped_q != '1)) stat_dropped_d = stat_dropped_q + 32'd1;
      if (if_valid_out && hazard && (stat_stall_q != '1)) stat_stall_d = stat_stall_q + 32'd1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stat_fetched_q <= '0;
         stat_dropped_q <= '0;
         stat_stall_q   <= '0;
      end else begin
         stat_fetched_q <= stat_fetched_d;
         stat_dropped_q <= stat_dropped_d;
         stat_stall_q   <= stat_stall_d;
      end
   end

   assign stat_fetched = stat_fetched_q;
   assign stat_dropped = stat_dropped_q;
   assign stat_stall   = stat_stall_q;
`endif

   // protocol and bookkeeping invariants
   always @(posedge clk) begin
      if (!rst) begin
         assert (!(Imem2proc_valid && (outstanding_q == '0)));
         assert (e_count <= CW'(QDEPTH));
         assert (t_count == outstanding_q - drop_cnt_q);
         assert (!(t_push && t_full));
         assert (!(t_pop && t_empty));
         assert (!(e_push && e_full && !e_pop));
      end
   end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Randomized scoreboard bench for if_fetch_queue with an in-bench memory and queue-level reference model.
module tb_if_fetch_queue;
   import if_pkg::*;

   localparam int unsigned XW = IF_XLEN;
   localparam int unsigned QD = IF_QDEPTH;

   logic          clk = 1'b0;
   logic          rst;
   logic          ex_take_branch_out;
   logic [XW-1:0] ex_target_PC_out;
   logic          hazard;
   logic          proc2Imem_req;
   logic [XW-1:0] proc2Imem_addr;
   logic          Imem2proc_gnt;
   logic          Imem2proc_valid;
   logic [XW-1:0] Imem2proc_data;
   logic          if_valid_out;
   logic [XW-1:0] if_PC_out, if_NPC_out, if_IR_out;
`ifdef IF_FETCH_STATS_EN
   logic [31:0]   stat_fetched, stat_dropped, stat_stall;
`endif

   always #5 clk = ~clk;

   if_fetch_queue #(.XLEN(XW), .QDEPTH(QD), .RESET_PC('0)) dut (
      .clk(clk), .rst(rst),
      .ex_take_branch_out(ex_take_branch_out), .ex_target_PC_out(ex_target_PC_out),
      .hazard(hazard),
      .proc2Imem_req(proc2Imem_req), .proc2Imem_addr(proc2Imem_addr),
      .Imem2proc_gnt(Imem2proc_gnt), .Imem2proc_valid(Imem2proc_valid),
      .Imem2proc_data(Imem2proc_data),
      .if_valid_out(if_valid_out), .if_PC_out(if_PC_out),
      .if_NPC_out(if_NPC_out), .if_IR_out(if_IR_out)
`ifdef IF_FETCH_STATS_EN
      ,
      .stat_fetched(stat_fetched), .stat_dropped(stat_dropped), .stat_stall(stat_stall)
`endif
   );

   typedef struct {
      logic [31:0] pc;
      int          ready;
      bit          wrong;
   } infl_t;

   infl_t        infl[$];
   fetch_entry_t expq[$];
   int           total = 0;
   int           bad = 0;
   int           cyc = 0;
   logic [31:0]  m_pc = '0;
   bit           exp_valid_now = 0;
   bit           pushed_now = 0;
   bit           stepped = 0;
   int unsigned  s_fetch = 0, s_drop = 0, s_stall = 0;

   function automatic logic [31:0] mem_word(logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ NOP;
   endfunction

   function automatic int live_count();
      int n = 0;
      foreach (infl[i]) if (!infl[i].wrong) n++;
      return n;
   endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   // one cycle: drive at negedge, check request side, advance the model
   task automatic step(int pb, int ph, int pg, int lmin, int lmax, int pv,
                       logic [31:0] tgt, bit fixed_tgt);
      bit          br, rv, exp_req;
      logic [31:0] target;
      infl_t       f;
      fetch_entry_t e;
      @(negedge clk);
      br     = ($urandom_range(99) < pb);
      target = fixed_tgt ? tgt : $urandom;
      rv     = 0;
      if (infl.size() > 0 && infl[0].ready <= cyc && $urandom_range(99) < pv) rv = 1;
      ex_take_branch_out = br;
      ex_target_PC_out   = target;
      hazard             = ($urandom_range(99) < ph);
      Imem2proc_gnt      = ($urandom_range(99) < pg);
      Imem2proc_valid    = rv;
      Imem2proc_data     = rv ? mem_word(infl[0].pc) : NOP;
      #1;
      exp_req = !br && ((expq.size() + live_count()) < QD);
      chk("req", 64'(proc2Imem_req), 64'(exp_req));
      chk("addr", 64'(proc2Imem_addr), 64'(m_pc));
      exp_valid_now = (expq.size() > 0) && !br;
      if (exp_valid_now && hazard) s_stall++;
      pushed_now = 0;
      if (rv) begin
         f = infl.pop_front();
         if (f.wrong || br) s_drop++;
         else begin
            e.pc = f.pc;
            e.ir = mem_word(f.pc);
            expq.push_back(e);
            pushed_now = 1;
            s_fetch++;
         end
      end
      if (br) begin
         foreach (infl[i]) infl[i].wrong = 1;
         expq.delete();
         pushed_now = 0;
      end
      if (exp_req && Imem2proc_gnt) begin
         f.pc    = m_pc;
         f.ready = cyc + int'($urandom_range(lmax, lmin));
         f.wrong = 0;
         infl.push_back(f);
         m_pc = m_pc + 32'd4;
      end
      if (br) m_pc = target & ~32'h3;
      stepped = 1;
      cyc++;
   endtask

   task automatic idle_inputs();
      ex_take_branch_out = 0;
      ex_target_PC_out   = '0;
      hazard             = 0;
      Imem2proc_gnt      = 0;
      Imem2proc_valid    = 0;
      Imem2proc_data     = NOP;
   endtask

   task automatic reset_model();
      infl.delete();
      expq.delete();
      m_pc    = '0;
      s_fetch = 0;
      s_drop  = 0;
      s_stall = 0;
   endtask

   task automatic check_reset_outputs(string tag);
      chk({tag, "_req"}, 64'(proc2Imem_req), 64'(0));
      chk({tag, "_valid"}, 64'(if_valid_out), 64'(0));
      chk({tag, "_pc"}, 64'(if_PC_out), 64'(0));
      chk({tag, "_npc"}, 64'(if_NPC_out), 64'(0));
      chk({tag, "_ir"}, 64'(if_IR_out), 64'(0));
   endtask

   // asynchronous reset asserted mid-cycle, away from any clock edge
   task automatic async_reset();
      @(negedge clk);
      idle_inputs();
      #2;
      rst = 1;
      #1;
      check_reset_outputs("async_rst");
      reset_model();
      @(posedge clk);
      @(negedge clk);
      rst = 0;
   endtask

   // monitor: head-of-queue checks against the scoreboard
   initial begin
      fetch_entry_t e;
      forever begin
         @(negedge clk);
         #2;
         if (stepped) begin
            stepped = 0;
            chk("valid", 64'(if_valid_out), 64'(exp_valid_now));
            if (if_valid_out && !hazard) begin
               if (expq.size() - int'(pushed_now) <= 0) begin
                  total++;
                  bad++;
                  $display("FAIL deq_empty cyc=%0d got_pc=%h want=none", cyc, if_PC_out);
               end else begin
                  e = expq.pop_front();
                  chk("head_pc", 64'(if_PC_out), 64'(e.pc));
                  chk("head_npc", 64'(if_NPC_out), 64'(e.pc + 32'd4));
                  chk("head_ir", 64'(if_IR_out), 64'(e.ir));
               end
            end
         end
      end
   end

   initial begin
      idle_inputs();
      rst = 0;
      #1;
      rst = 1;
      @(negedge clk);
      check_reset_outputs("reset");
      @(negedge clk);
      rst = 0;

      // streaming with 1-cycle memory
      repeat (30) step(0, 0, 100, 1, 1, 100, '0, 0);
      // downstream stall fills the queue, then release
      repeat (12) step(0, 100, 100, 1, 1, 100, '0, 0);
      repeat (12) step(0, 0, 100, 1, 1, 100, '0, 0);
      // 3-cycle memory, redirect to unaligned target
      repeat (6) step(0, 100, 100, 3, 3, 100, '0, 0);
      step(100, 0, 100, 3, 3, 100, 32'h103, 1);
      repeat (15) step(0, 0, 100, 3, 3, 100, '0, 0);
      // redirect while the queue is full / a response lands
      repeat (8) step(0, 100, 100, 2, 2, 100, '0, 0);
      step(100, 100, 100, 2, 2, 100, '0, 0);
      repeat (10) step(0, 0, 100, 2, 2, 100, '0, 0);
      // async reset with requests in flight
      repeat (4) step(0, 0, 100, 3, 3, 100, '0, 0);
      async_reset();
      repeat (10) step(0, 0, 100, 1, 2, 100, '0, 0);
      // grant withheld: address must hold
      repeat (5) step(0, 0, 0, 1, 1, 100, '0, 0);
      // random mix
      repeat (3000) step(5, 30, 70, 1, 4, 80, '0, 0);
      // drain everything
      repeat (30) step(0, 0, 0, 1, 4, 100, '0, 0);

      @(negedge clk);
      #1;
      chk("drained_valid", 64'(if_valid_out), 64'(0));
`ifdef IF_FETCH_STATS_EN
      chk("stat_fetched", 64'(stat_fetched), 64'(s_fetch));
      chk("stat_dropped", 64'(stat_dropped), 64'(s_drop));
      chk("stat_stall", 64'(stat_stall), 64'(s_stall));
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
